// File: rtl/rv32_types_pkg.sv
// rtl/rv32_types_pkg.sv - shared pipeline types for the rv32 core
package rv32_types;

    typedef struct packed {
        logic        do_jump;
        logic [31:0] to;
    } jump_request_t;

    typedef struct packed {
        logic        do_interrupt;
        logic [31:0] to;
    } interrupt_request_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        generate_nop;
    } fetch_decode_buffer_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/rv32_fetch_pc_select.sv
// rtl/rv32_fetch_pc_select.sv - priority mux choosing the next fetch address
module rv32_fetch_pc_select
    import rv32_types::*;
(
    input  interrupt_request_t interrupt_request,
    input  jump_request_t      jump_request,
    input  logic               pend_valid,
    input  logic [31:0]        pend_pc,
    input  logic               stall,
    input  logic               dec_nop,
    input  logic [31:0]        dec_pc,
    input  logic [31:0]        fpc,
    output logic [31:0]        addr,
    output logic               redirect,
    output logic               replay
);

    always_comb begin
        addr     = fpc;
        redirect = 1'b1;
        replay   = 1'b0;
        if (interrupt_request.do_interrupt) begin
            addr = align_word(interrupt_request.to);
        end else if (jump_request.do_jump) begin
            addr = align_word(jump_request.to);
        end else if (pend_valid) begin
            addr = pend_pc;
        end else if (stall && !dec_nop) begin
            // a bubble in decode has nothing worth replaying
            addr     = dec_pc;
            redirect = 1'b0;
            replay   = 1'b1;
        end else begin
            redirect = 1'b0;
        end
    end

endmodule

// File: rtl/rv32_fetch_stage.sv
// rtl/rv32_fetch_stage.sv - fetch stage feeding the fetch/decode buffer
module rv32_fetch_stage
    import rv32_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 stop,
    input  logic                 stall,
    input  jump_request_t        jump_request,
    input  interrupt_request_t   interrupt_request,
    output fetch_decode_buffer_t fetch_decode_buff,
    output logic [31:0]          instr_addr,
    output logic                 instr_req,
    input  logic                 instr_gnt,
    output logic [31:0]          fetch_count
);

    logic [31:0]  dec_pc;
    logic         dec_nop;
    logic [31:0]  fpc;
    logic [31:0]  last_addr;
    logic         pend_valid;
    logic [31:0]  pend_pc;
    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0]  sel_addr;
    logic         redirect;
    logic         replay;

    rv32_fetch_pc_select u_pc_select (
        .interrupt_request (interrupt_request),
        .jump_request      (jump_request),
        .pend_valid        (pend_valid),
        .pend_pc           (pend_pc),
        .stall             (stall),
        .dec_nop           (dec_nop),
        .dec_pc            (dec_pc),
        .fpc               (fpc),
        .addr              (sel_addr),
        .redirect          (redirect),
        .replay            (replay)
    );

    // during a freeze the memory must keep seeing the request it already accepted
    assign instr_addr = stop ? last_addr : sel_addr;
    assign instr_req  = resetn;

    assign fetch_decode_buff.pc           = dec_pc;
    assign fetch_decode_buff.generate_nop = dec_nop;

    always_comb begin
        state_next = state;
        if (!stop) begin
            if (!instr_gnt) begin
                state_next = (state == BOOT) ? BOOT : MISS;
            end else if (!replay) begin
                state_next = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= BOOT;
            dec_pc      <= RESET_PC;
            dec_nop     <= 1'b1;
            fpc         <= RESET_PC;
            last_addr   <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_pc     <= 32'd0;
            fetch_count <= 32'd0;
        end else begin
            state <= state_next;
            if (stop) begin
                if (interrupt_request.do_interrupt) begin
                    pend_valid <= 1'b1;
                    pend_pc    <= align_word(interrupt_request.to);
                end else if (jump_request.do_jump) begin
                    pend_valid <= 1'b1;
                    pend_pc    <= align_word(jump_request.to);
                end
            end else begin
                last_addr  <= sel_addr;
                pend_valid <= 1'b0;
                if (!instr_gnt) begin
                    dec_nop <= 1'b1;
                    fpc     <= sel_addr;
                end else if (redirect || !replay) begin
                    dec_pc      <= sel_addr;
                    dec_nop     <= 1'b0;
                    fpc         <= sel_addr + 32'd4;
                    fetch_count <= fetch_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32_fetch_stage.sv
// tb/tb_rv32_fetch_stage.sv - self-checking bench for rv32_fetch_stage
module tb_rv32_fetch_stage;
    import rv32_types::*;

    localparam logic [31:0] RST = 32'h8000_0000;

    logic                 clk = 1'b0;
    logic                 resetn, stop, stall, gnt;
    jump_request_t        jr;
    interrupt_request_t   ir;
    fetch_decode_buffer_t fdb;
    logic [31:0]          instr_addr, fetch_count;
    logic                 instr_req;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_pc, m_fpc, m_last, m_ppc, m_cnt;
    logic        m_nop, m_pv;

    rv32_fetch_stage #(.RESET_PC(RST)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .stop              (stop),
        .stall             (stall),
        .jump_request      (jr),
        .interrupt_request (ir),
        .fetch_decode_buff (fdb),
        .instr_addr        (instr_addr),
        .instr_req         (instr_req),
        .instr_gnt         (gnt),
        .fetch_count       (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_sel();
        if (ir.do_interrupt) return ir.to & ~32'd3;
        if (jr.do_jump) return jr.to & ~32'd3;
        if (m_pv) return m_ppc;
        if (stall && !m_nop) return m_pc;
        return m_fpc;
    endfunction

    function automatic logic [31:0] m_addr();
        return stop ? m_last : m_sel();
    endfunction

    task automatic set_jump(input logic d, input logic [31:0] t);
        jr.do_jump = d;
        jr.to      = t;
    endtask

    task automatic set_irq(input logic d, input logic [31:0] t);
        ir.do_interrupt = d;
        ir.to           = t;
    endtask

    task automatic step();
        logic [31:0] a;
        logic        redir, rep;
        if (!resetn) begin
            m_pc = RST; m_nop = 1'b1; m_fpc = RST; m_last = RST;
            m_pv = 1'b0; m_ppc = 32'd0; m_cnt = 32'd0;
        end else if (stop) begin
            if (ir.do_interrupt) begin
                m_pv = 1'b1; m_ppc = ir.to & ~32'd3;
            end else if (jr.do_jump) begin
                m_pv = 1'b1; m_ppc = jr.to & ~32'd3;
            end
        end else begin
            a     = m_sel();
            redir = ir.do_interrupt || jr.do_jump || m_pv;
            rep   = !redir && stall && !m_nop;
            if (!gnt) begin
                m_nop = 1'b1; m_fpc = a;
            end else if (!rep) begin
                m_pc = a; m_nop = 1'b0; m_fpc = a + 32'd4; m_cnt = m_cnt + 32'd1;
            end
            m_pv   = 1'b0;
            m_last = a;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; stop = 1'b0; stall = 1'b0; gnt = 1'b1;
        set_jump(1'b0, 32'd0); set_irq(1'b0, 32'd0);
        step(); step();
        vectors++; if (fdb.pc !== RST) begin miscompares++; $display("FAIL reset_pc: got %h want %h", fdb.pc, RST); end
        vectors++; if (fdb.generate_nop !== 1'b1) begin miscompares++; $display("FAIL reset_nop: got %b want 1", fdb.generate_nop); end
        vectors++; if (fetch_count !== 32'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
        vectors++; if (instr_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", instr_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] e;
        resetn = 1'b1; gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e = RST + 32'(4 * i);
            @(negedge clk);
            vectors++; if (instr_addr !== e) begin miscompares++; $display("FAIL seq_addr%0d: got %h want %h", i, instr_addr, e); end
            vectors++; if (instr_req !== 1'b1) begin miscompares++; $display("FAIL seq_req%0d: got %b want 1", i, instr_req); end
            step();
            vectors++; if (fdb.pc !== e || fdb.generate_nop !== 1'b0) begin miscompares++; $display("FAIL seq_pc%0d: got %h/%b want %h/0", i, fdb.pc, fdb.generate_nop, e); end
            if (i == 2) begin
                vectors++; if (fetch_count !== 32'd3) begin miscompares++; $display("FAIL seq_count3: got %0d want 3", fetch_count); end
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++; if (instr_addr !== 32'h8000_0010) begin miscompares++; $display("FAIL stall_addr%0d: got %h want 80000010", i, instr_addr); end
            step();
            vectors++; if (fdb.pc !== 32'h8000_0010 || fetch_count !== 32'd5) begin miscompares++; $display("FAIL stall_hold%0d: got %h/%0d want 80000010/5", i, fdb.pc, fetch_count); end
        end
        stall = 1'b0;
        @(negedge clk);
        vectors++; if (instr_addr !== 32'h8000_0014) begin miscompares++; $display("FAIL stall_resume: got %h want 80000014", instr_addr); end
        step();
    endtask

    task automatic test_redirect();
        stall = 1'b1;
        set_jump(1'b1, 32'h8000_0102); set_irq(1'b1, 32'h8000_0200);
        @(negedge clk);
        vectors++; if (instr_addr !== 32'h8000_0200) begin miscompares++; $display("FAIL irq_addr: got %h want 80000200", instr_addr); end
        step();
        stall = 1'b0; set_jump(1'b0, 32'd0); set_irq(1'b0, 32'd0);
        vectors++; if (fdb.pc !== 32'h8000_0200 || fdb.generate_nop !== 1'b0) begin miscompares++; $display("FAIL irq_pc: got %h/%b want 80000200/0", fdb.pc, fdb.generate_nop); end
        @(negedge clk);
        vectors++; if (instr_addr !== 32'h8000_0204) begin miscompares++; $display("FAIL irq_next: got %h want 80000204", instr_addr); end
        step();
        set_jump(1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        vectors++; if (instr_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL jump_align: got %h want fffffffc", instr_addr); end
        step();
        set_jump(1'b0, 32'd0);
        @(negedge clk);
        vectors++; if (instr_addr !== 32'd0) begin miscompares++; $display("FAIL fpc_wrap: got %h want 00000000", instr_addr); end
        step();
    endtask

    task automatic test_miss();
        set_jump(1'b1, 32'h8000_001C);
        step();
        set_jump(1'b0, 32'd0);
        gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (instr_addr !== 32'h8000_0020) begin miscompares++; $display("FAIL miss_addr%0d: got %h want 80000020", i, instr_addr); end
            step();
            vectors++; if (fdb.generate_nop !== 1'b1) begin miscompares++; $display("FAIL miss_nop%0d: got %b want 1", i, fdb.generate_nop); end
        end
        gnt = 1'b1;
        @(negedge clk);
        vectors++; if (instr_addr !== 32'h8000_0020) begin miscompares++; $display("FAIL miss_retry: got %h want 80000020", instr_addr); end
        step();
        vectors++; if (fdb.pc !== 32'h8000_0020 || fdb.generate_nop !== 1'b0) begin miscompares++; $display("FAIL miss_grant: got %h/%b want 80000020/0", fdb.pc, fdb.generate_nop); end
    endtask

    task automatic test_stop();
        logic [31:0] cnt0;
        cnt0 = m_cnt;
        stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_jump(i == 1, 32'h8000_0400);
            @(negedge clk);
            vectors++; if (instr_addr !== 32'h8000_0020) begin miscompares++; $display("FAIL stop_addr%0d: got %h want 80000020", i, instr_addr); end
            step();
            vectors++; if (fdb.pc !== 32'h8000_0020 || fetch_count !== cnt0) begin miscompares++; $display("FAIL stop_hold%0d: got %h/%0d want 80000020/%0d", i, fdb.pc, fetch_count, cnt0); end
        end
        set_jump(1'b0, 32'd0);
        stop = 1'b0;
        @(negedge clk);
        vectors++; if (instr_addr !== 32'h8000_0400) begin miscompares++; $display("FAIL stop_pending: got %h want 80000400", instr_addr); end
        step();
        vectors++; if (fdb.pc !== 32'h8000_0400) begin miscompares++; $display("FAIL stop_pc: got %h want 80000400", fdb.pc); end
    endtask

    task automatic test_reset_mid();
        gnt = 1'b0;
        step();
        stop = 1'b1; set_jump(1'b1, 32'h8000_0800);
        step();
        set_jump(1'b0, 32'd0); stop = 1'b0; resetn = 1'b0;
        step();
        vectors++; if (fdb.pc !== RST || fdb.generate_nop !== 1'b1 || fetch_count !== 32'd0) begin miscompares++; $display("FAIL midreset_state: got %h/%b/%0d want %h/1/0", fdb.pc, fdb.generate_nop, fetch_count, RST); end
        resetn = 1'b1; gnt = 1'b1;
        @(negedge clk);
        vectors++; if (instr_addr !== RST) begin miscompares++; $display("FAIL midreset_drop: got %h want %h", instr_addr, RST); end
        step();
        vectors++; if (fdb.pc !== RST) begin miscompares++; $display("FAIL midreset_pc: got %h want %h", fdb.pc, RST); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            resetn = ($urandom_range(0, 63) != 0);
            stop   = ($urandom_range(0, 7) == 0);
            stall  = ($urandom_range(0, 3) == 0);
            gnt    = ($urandom_range(0, 4) != 0);
            set_jump($urandom_range(0, 9) == 0, $urandom);
            set_irq($urandom_range(0, 19) == 0, $urandom);
            @(negedge clk);
            if (resetn) begin
                vectors++; if (instr_addr !== m_addr()) begin miscompares++; $display("FAIL rnd_addr%0d: got %h want %h", i, instr_addr, m_addr()); end
            end
            step();
            vectors++;
            if (fdb.pc !== m_pc || fdb.generate_nop !== m_nop || fetch_count !== m_cnt) begin
                miscompares++;
                $display("FAIL rnd_state%0d: got %h/%b/%0d want %h/%b/%0d", i, fdb.pc, fdb.generate_nop, fetch_count, m_pc, m_nop, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_miss();
        test_stop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rv32_fetch_stage.md
# rv32_fetch_stage

CPU stage 1, the producer side of `fetch_decode_buffer_t`.
- Generates the instruction-memory read address every cycle.
- Registers the PC and bubble flag consumed by the decode stage one cycle later, when synchronous instruction memory presents `instr`.
- Handles boot, sequential fetch, replay on decode stall, jump/interrupt redirection, memory non-grant and global pipeline freeze.

## Interface

Parameters:
- `RESET_PC`, default 32'h8000_0000, first fetch address after reset (bits [1:0] must be 0).

Ports:
- `clk` in 1: clock.
- `resetn` in 1: synchronous, active-low reset.
- `stop` in 1: global pipeline freeze (same signal decode receives).
- `stall` in 1: decode hazard stall.
- `jump_request` in `jump_request_t`: `do_jump`, `to`.
- `interrupt_request` in `interrupt_request_t`: `do_interrupt`, `to`.
- `fetch_decode_buff` out `fetch_decode_buffer_t`: `pc`, `generate_nop`.
- `instr_addr` out 32: memory read address, combinational, bits [1:0] always 0.
- `instr_req` out 1: read request.
- `instr_gnt` in 1: memory accepted this cycle's request; data is valid next cycle.
- `fetch_count` out 32: count of instructions delivered to decode, wraps.

## Operation

Registers:
- `dec_pc`/`dec_nop`, which form `fetch_decode_buff`.
- `fpc`, the next sequential fetch address.
- `last_addr`, the address issued last cycle.
- `pend_valid`/`pend_pc`, a redirect captured during `stop`.
- FSM state: BOOT, RUN, MISS.
- `fetch_count`.

Address select, in strict priority:
1. `interrupt_request.do_interrupt` → `interrupt_request.to`
2. `jump_request.do_jump` → `jump_request.to`
3. `pend_valid` → `pend_pc`
4. `stall & !dec_nop` → `dec_pc` (replay)
5. otherwise → `fpc`

Redirect targets have bits [1:0] forced to 0.

`stop=1`:
- `instr_addr = last_addr` and `instr_req = 1`.
- Every register holds, except that a redirect present this cycle is latched into `pend_valid`/`pend_pc`. Interrupt wins over jump; a later redirect overwrites an earlier one.

`stop=0`, with `addr` = the selected address:
- Redirect or normal fetch with `gnt=1`:
  - `dec_pc <= addr`, `dec_nop <= 0`, `fpc <= addr+4` (mod 2^32).
  - `pend_valid <= 0`; `fetch_count++`.
  - State → RUN.
- Replay (case 4) with `gnt=1`:
  - `dec_pc`, `dec_nop`, `fpc` hold; no count.
- Any case with `gnt=0`:
  - `dec_nop <= 1`; `fpc <= addr` (retry the same address).
  - `pend_valid <= 0`; state → MISS.
  - A stalled instruction is thereby turned into a bubble and refetched.
- `stall` is ignored while `dec_nop=1`.

FSM:
- BOOT: entered on reset, with `fpc = RESET_PC`. Issues `fpc`. On grant → RUN; otherwise stays in BOOT.
- RUN ↔ MISS: transitions follow `instr_gnt` as described above.
- Redirects are honoured in every state, including BOOT.

## Timing

- Reset values (while `resetn=0`):
  - `fetch_decode_buff.pc = RESET_PC`, `generate_nop = 1`.
  - `fpc = RESET_PC`, `last_addr = RESET_PC`, `pend_valid = 0`, `fetch_count = 0`, state BOOT.
  - `instr_req = 0`.
- Reset mid-operation discards pending redirects and misses.
- Latency: an address issued in cycle N with grant appears as `fetch_decode_buff.pc` in cycle N+1, alongside `instr` from memory.
- Redirect penalty: zero fetch bubbles (the decode stage kills its own slot). The target is in decode at N+1.
- Simultaneous interrupt + jump: interrupt target only.
- Simultaneous redirect + stall: redirect wins, no replay.
- `fpc` wrap: 32'hFFFF_FFFC + 4 = 0.
- `fetch_count` wraps from 32'hFFFF_FFFF to 0.

## Structure

Add to `rv32_types`:
- the `fetch_decode_buffer_t` fields above;
- `fetch_state_t` enum {BOOT, RUN, MISS};
- `jump_request_t.to` and `interrupt_request_t.to`.

One sub-module, `rv32_fetch_pc_select`: the combinational priority address mux including alignment forcing. The FSM, registers and counter stay in the stage.

## Test plan

- Reset, release, `gnt=1` constant → `instr_addr` 80000000, 80000004, 80000008; `pc` trails one cycle; `generate_nop` 1 then 0; `fetch_count = 3` after 3 cycles.
- `stall=1` for 2 cycles with `pc=80000010` → `instr_addr` 80000010 both cycles, `pc` holds, count frozen; resumes at 80000014.
- `do_jump`, `to = 80000102`, with `do_interrupt`, `to = 80000200` in the same cycle → `instr_addr = 80000200`; next `pc = 80000200`, next fetch 80000204.
- `gnt=0` for 3 cycles at `fpc = 80000020` → `generate_nop = 1` for 3 cycles, state MISS, same address reissued; on grant `pc = 80000020`.
- `stop=1` while `do_jump`, `to = 80000400` pulses → `instr_addr = last_addr`, outputs frozen; first cycle with `stop=0` → `instr_addr = 80000400`.
- Assert `resetn=0` during MISS with a pending redirect → BOOT, `pc = RESET_PC`, `generate_nop = 1`, pending redirect dropped.
